// File: rtl/controle_cofre.sv
// Safe controller: owns the stored password and latched attempt, sequences
// check/open/relock/lockout from the external comparator flags, drives status LEDs.
module controle_cofre #(
   parameter int MAX_TENTATIVAS = 3,
   parameter int T_BLOQUEIO     = 50000000,
   parameter int T_ABERTO       = 250000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] senha_nova,
   input  logic [3:0] tentativa,
   input  logic       btn_confirmar,
   input  logic       btn_gravar,
   input  logic       btn_fechar,
   input  logic       cmp_igual,
   input  logic       cmp_ate3,
   output logic [3:0] senha_reg,
   output logic [3:0] tent_reg,
   output logic       led0,
   output logic       led1,
   output logic       led2,
   output logic       bloqueado,
   output logic [2:0] erros
);

   localparam int T_MAX = (T_BLOQUEIO > T_ABERTO) ? T_BLOQUEIO : T_ABERTO;
   localparam int TW    = $clog2(T_MAX + 1);
   localparam logic [TW-1:0] CARGA_ABERTO = TW'(T_ABERTO - 1);
   localparam logic [TW-1:0] CARGA_BLOQ   = TW'(T_BLOQUEIO - 1);
   localparam logic [2:0]    ERROS_MAX    = 3'(MAX_TENTATIVAS);
   localparam logic [3:0]    LIMITE       = 4'(MAX_TENTATIVAS);

   typedef enum logic [1:0] {FECHADO, VERIFICA, ABERTO, BLOQUEADO} estado_t;

   estado_t       estado, estado_prox;
   logic [TW-1:0] timer, timer_prox;
   logic [3:0]    senha_prox, tent_prox;
   logic          led0_prox, led1_prox, led2_prox, bloq_prox;
   logic [2:0]    erros_prox;
   logic [3:0]    erros_inc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado    <= FECHADO;
         timer     <= '0;
         senha_reg <= '0;
         tent_reg  <= '0;
         led0      <= 1'b0;
         led1      <= 1'b0;
         led2      <= 1'b0;
         bloqueado <= 1'b0;
         erros     <= '0;
      end else begin
         estado    <= estado_prox;
         timer     <= timer_prox;
         senha_reg <= senha_prox;
         tent_reg  <= tent_prox;
         led0      <= led0_prox;
         led1      <= led1_prox;
         led2      <= led2_prox;
         bloqueado <= bloq_prox;
         erros     <= erros_prox;
      end
   end

   // One shared down-counter, reloaded when entering ABERTO or BLOQUEADO.
   always_comb begin
      estado_prox = estado;
      timer_prox  = timer;
      senha_prox  = senha_reg;
      tent_prox   = tent_reg;
      led0_prox   = led0;
      led1_prox   = led1;
      led2_prox   = led2;
      bloq_prox   = bloqueado;
      erros_prox  = erros;
      erros_inc   = {1'b0, erros} + 4'd1;

      case (estado)
         FECHADO: begin
            if (btn_confirmar) begin
               tent_prox   = tentativa;
               estado_prox = VERIFICA;
            end
         end
         VERIFICA: begin
            if (cmp_igual) begin
               estado_prox = ABERTO;
               led0_prox   = 1'b1;
               led1_prox   = 1'b0;
               led2_prox   = 1'b0;
               erros_prox  = '0;
               timer_prox  = CARGA_ABERTO;
            end else if (erros_inc < LIMITE) begin
               estado_prox = FECHADO;
               erros_prox  = erros_inc[2:0];
               led2_prox   = 1'b1;
               led1_prox   = cmp_ate3;
            end else begin
               estado_prox = BLOQUEADO;
               erros_prox  = ERROS_MAX;
               led2_prox   = 1'b1;
               led1_prox   = cmp_ate3;
               bloq_prox   = 1'b1;
               timer_prox  = CARGA_BLOQ;
            end
         end
         ABERTO: begin
            if (btn_gravar) begin
               senha_prox = senha_nova;
            end
            if (btn_fechar || timer == '0) begin
               estado_prox = FECHADO;
               led0_prox   = 1'b0;
               timer_prox  = '0;
            end else begin
               timer_prox = timer - TW'(1);
            end
         end
         BLOQUEADO: begin
            if (timer == '0) begin
               estado_prox = FECHADO;
               bloq_prox   = 1'b0;
               erros_prox  = '0;
               led1_prox   = 1'b0;
               led2_prox   = 1'b0;
            end else begin
               timer_prox = timer - TW'(1);
            end
         end
         default: estado_prox = FECHADO;
      endcase
   end

endmodule
